// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: a phase accumulator yields an oversample tick,
// and every OVERSAMPLE-th oversample tick is also the 1x bit tick.
module baud_tick_gen #(
  parameter int          ACC_WIDTH  = 16,
  parameter int          OVERSAMPLE = 16,
  parameter int unsigned INC_RESET  = 2416,
  localparam int         PHASE_W    = $clog2(OVERSAMPLE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 resync,
  input  logic [ACC_WIDTH-1:0] inc_in,
  input  logic                 inc_load,
  output logic                 inc_pending,
  output logic                 os_tick,
  output logic                 baud_tick,
  output logic [PHASE_W-1:0]   os_phase
);

  localparam logic [ACC_WIDTH-1:0] INC_INIT  = ACC_WIDTH'(INC_RESET);
  localparam logic [PHASE_W-1:0]   PHASE_MAX = PHASE_W'(OVERSAMPLE - 1);

  logic [ACC_WIDTH-1:0] frac;
  logic                 carry;
  logic [ACC_WIDTH-1:0] inc_active;
  logic [ACC_WIDTH-1:0] inc_staged;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] next_inc;
  logic                 apply_now;

  // The prior carry is deliberately dropped: only the fraction feeds the adder.
  assign sum = {1'b0, frac} + {1'b0, inc_active};

  // A load coinciding with an apply edge bypasses the staging register.
  assign next_inc  = inc_load ? inc_in : inc_staged;
  assign apply_now = baud_tick | ~en | (inc_active == '0);

  assign os_tick   = carry;
  assign baud_tick = carry & (os_phase == PHASE_MAX);

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; baud_tick/apply_now therefore see the old phase and carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frac        <= '0;
      carry       <= 1'b0;
      os_phase    <= '0;
      inc_active  <= INC_INIT;
      inc_staged  <= INC_INIT;
      inc_pending <= 1'b0;
    end else if (resync) begin
      frac        <= '0;
      carry       <= 1'b0;
      os_phase    <= '0;
      inc_active  <= next_inc;
      inc_pending <= 1'b0;
      if (inc_load) inc_staged <= inc_in;
    end else begin
      if (carry) os_phase <= os_phase + 1'b1;

      if (en) {carry, frac} <= sum;
      else    carry         <= 1'b0;

      if (inc_load) inc_staged <= inc_in;

      if (apply_now) begin
        inc_active  <= next_inc;
        inc_pending <= 1'b0;
      end else if (inc_load) begin
        inc_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: a vector table for single-edge behaviour plus
// hand-written multi-cycle sequences with hand-computed tick positions and counts.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n, en, resync, inc_load;
  logic [15:0] inc_in;
  logic        inc_pending, os_tick, baud_tick;
  logic [3:0]  os_phase;

  int checks   = 0;
  int failures = 0;

  baud_tick_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .resync     (resync),
    .inc_in     (inc_in),
    .inc_load   (inc_load),
    .inc_pending(inc_pending),
    .os_tick    (os_tick),
    .baud_tick  (baud_tick),
    .os_phase   (os_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, en, resync, inc_load;
    logic [15:0] inc_in;
    logic        os_tick, baud_tick;
    logic [3:0]  os_phase;
    logic        inc_pending;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic e, input logic rs, input logic ld,
                     input logic [15:0] inc, input logic t, input logic b,
                     input logic [3:0] ph, input logic p);
    vec_t v;
    v = '{r, e, rs, ld, inc, t, b, ph, p};
    vecs.push_back(v);
  endtask

  task automatic run_until_phase(input logic [3:0] target, input int bound, input string name);
    int k = 0;
    while (os_phase !== target && k < bound) begin
      cyc();
      k++;
    end
    check(name, os_phase, target);
  endtask

  // Expected os_tick for cycle n of the long rate/deferred-load run.
  function automatic bit exp_tick(input int n);
    if (n <= 192)      return (n % 4) == 0;
    else if (n <= 225) return (n >= 195) && (n % 2 == 1);
    else               return (n >= 228) && ((n - 228) % 8 == 0);
  endfunction

  function automatic bit exp_pend(input int n);
    return (n >= 142 && n <= 192) || (n >= 200 && n <= 225);
  endfunction

  function automatic bit exp_baud(input int n);
    return (n == 64) || (n == 128) || (n == 192) || (n == 225);
  endfunction

  initial begin
    int tick_cnt, baud_cnt, consec, first_tick;
    logic prev;
    logic [3:0] ph;

    rst_n = 1'b0; en = 1'b0; resync = 1'b0; inc_load = 1'b0; inc_in = '0;
    @(negedge clk);

    // ---- single-edge vector table ----
    add(0,0,0,0,16'd0,     0,0,4'd0,0);  // reset
    add(1,0,0,1,16'd16384, 0,0,4'd0,0);  // load while disabled applies directly
    add(1,1,0,0,16'd0,     0,0,4'd0,0);
    add(1,1,0,0,16'd0,     0,0,4'd0,0);
    add(1,1,0,0,16'd0,     0,0,4'd0,0);
    add(1,1,0,0,16'd0,     1,0,4'd0,0);  // 4th enabled update overflows
    add(1,1,0,0,16'd0,     0,0,4'd1,0);
    add(1,1,0,1,16'd32768, 0,0,4'd1,1);  // mid-period load is staged
    add(1,1,0,0,16'd0,     0,0,4'd1,1);
    add(1,0,0,0,16'd0,     0,0,4'd1,0);  // en=0 applies staged value, clears carry
    add(1,1,0,0,16'd0,     1,0,4'd1,0);  // 49152+32768 overflows
    add(1,1,0,0,16'd0,     0,0,4'd2,0);
    add(1,1,0,0,16'd0,     1,0,4'd2,0);
    add(1,1,1,0,16'd0,     0,0,4'd0,0);  // resync clears phase and accumulator
    add(1,1,0,0,16'd0,     0,0,4'd0,0);
    add(1,1,0,0,16'd0,     1,0,4'd0,0);
    add(1,1,0,1,16'd8192,  0,0,4'd1,1);
    add(1,1,1,0,16'd0,     0,0,4'd0,0);  // resync applies pending 8192
    for (int i = 0; i < 7; i++) add(1,1,0,0,16'd0, 0,0,4'd0,0);
    add(1,1,0,0,16'd0,     1,0,4'd0,0);  // 8th update at 8192
    add(0,1,0,0,16'd0,     0,0,4'd0,0);  // reset

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en; resync = vecs[i].resync;
      inc_load = vecs[i].inc_load; inc_in = vecs[i].inc_in;
      cyc();
      check($sformatf("vec%0d os_tick", i),     os_tick,     vecs[i].os_tick);
      check($sformatf("vec%0d baud_tick", i),   baud_tick,   vecs[i].baud_tick);
      check($sformatf("vec%0d os_phase", i),    os_phase,    vecs[i].os_phase);
      check($sformatf("vec%0d inc_pending", i), inc_pending, vecs[i].inc_pending);
    end

    // ---- basic rate, phase wrap and deferred loads at inc=16384 ----
    rst_n = 1'b0; en = 1'b0; resync = 1'b0; inc_load = 1'b0;
    cyc();
    rst_n = 1'b1; inc_load = 1'b1; inc_in = 16'd16384;
    cyc();
    inc_load = 1'b0; en = 1'b1;
    ph = '0;
    for (int n = 1; n <= 260; n++) begin
      inc_load = (n == 142) || (n == 200) || (n == 205);
      inc_in   = (n == 142) ? 16'd32768 : (n == 200) ? 16'd16384 : 16'd8192;
      cyc();
      check($sformatf("run c%0d os_tick", n),     os_tick,     exp_tick(n));
      check($sformatf("run c%0d baud_tick", n),   baud_tick,   exp_baud(n));
      check($sformatf("run c%0d inc_pending", n), inc_pending, exp_pend(n));
      check($sformatf("run c%0d os_phase", n),    os_phase,    ph);
      if (exp_tick(n)) ph = ph + 4'd1;
    end
    inc_load = 1'b0;

    // ---- enable gap holds phase; resync realigns ----
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; en = 1'b0; inc_load = 1'b1; inc_in = 16'd16384; cyc();
    inc_load = 1'b0; en = 1'b1;
    for (int n = 0; n < 6; n++) cyc();
    en = 1'b0; tick_cnt = 0;
    for (int n = 0; n < 10; n++) begin cyc(); tick_cnt += os_tick; end
    check("gap ticks", tick_cnt, 0);
    en = 1'b1;
    cyc(); check("resume c1 os_tick", os_tick, 0);
    cyc(); check("resume c2 os_tick", os_tick, 1);
    run_until_phase(4'd9, 200, "reach phase 9");
    resync = 1'b1; cyc(); resync = 1'b0;
    check("resync os_phase", os_phase, 0);
    check("resync os_tick", os_tick, 0);
    tick_cnt = 0;
    for (int n = 0; n < 3; n++) begin cyc(); tick_cnt += os_tick; end
    check("post-resync early ticks", tick_cnt, 0);
    cyc(); check("post-resync c4 os_tick", os_tick, 1);

    // ---- increment of 0, then 65535 ----
    en = 1'b0; inc_load = 1'b1; inc_in = 16'd0; cyc();
    inc_load = 1'b0; en = 1'b1; tick_cnt = 0;
    for (int n = 0; n < 2000; n++) begin cyc(); tick_cnt += os_tick; end
    check("inc0 ticks", tick_cnt, 0);
    inc_load = 1'b1; inc_in = 16'd65535; cyc(); inc_load = 1'b0;
    check("inc0 load immediate pending", inc_pending, 0);
    resync = 1'b1; cyc(); resync = 1'b0; tick_cnt = 0;
    for (int n = 0; n < 4096; n++) begin cyc(); tick_cnt += os_tick; end
    check("inc65535 ticks/4096", tick_cnt, 4095);

    // ---- default increment: first tick, fractional counts, pulse width ----
    rst_n = 1'b0; cyc();
    check("reset os_tick", os_tick, 0);
    check("reset baud_tick", baud_tick, 0);
    check("reset os_phase", os_phase, 0);
    check("reset inc_pending", inc_pending, 0);
    rst_n = 1'b1; en = 1'b1;
    tick_cnt = 0; baud_cnt = 0; consec = 0; first_tick = 0; prev = 1'b0;
    for (int n = 1; n <= 32768; n++) begin
      cyc();
      if (os_tick && first_tick == 0) first_tick = n;
      if (os_tick && prev) consec++;
      tick_cnt += os_tick; baud_cnt += baud_tick; prev = os_tick;
    end
    check("default first tick cycle", first_tick, 28);
    check("default os_tick count", tick_cnt, 1208);
    check("default baud_tick count", baud_cnt, 75);
    check("default consecutive ticks", consec, 0);

    // ---- reset while a load is pending ----
    run_until_phase(4'd7, 2000, "reach phase 7");
    inc_load = 1'b1; inc_in = 16'd16384; cyc(); inc_load = 1'b0;
    check("pre-reset inc_pending", inc_pending, 1);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    check("midreset os_tick", os_tick, 0);
    check("midreset baud_tick", baud_tick, 0);
    check("midreset os_phase", os_phase, 0);
    check("midreset inc_pending", inc_pending, 0);
    first_tick = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (os_tick && first_tick == 0) first_tick = n;
    end
    check("midreset first tick cycle", first_tick, 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
